// File: rtl/sdf_r2_butterfly_stage_if.sv
// Stream bundle for one radix-2 SDF butterfly stage.
// Slave side is the stage itself; master side feeds it and takes its output.
interface sdf_r2_butterfly_stage_if #(
    parameter int DATA_W = 14
);
    logic                     in_valid;
    logic                     in_sof;
    logic signed [DATA_W-1:0] in_real;
    logic signed [DATA_W-1:0] in_imag;
    logic                     out_valid;
    logic                     out_bf;
    logic signed [DATA_W-1:0] out_real;
    logic signed [DATA_W-1:0] out_imag;

    modport slave (
        input  in_valid,
        input  in_sof,
        input  in_real,
        input  in_imag,
        output out_valid,
        output out_bf,
        output out_real,
        output out_imag
    );

    modport master (
        output in_valid,
        output in_sof,
        output in_real,
        output in_imag,
        input  out_valid,
        input  out_bf,
        input  out_real,
        input  out_imag
    );
endinterface

// File: rtl/sdf_r2_butterfly_stage.sv
// Radix-2 single-path delay-feedback butterfly stage, stall tolerant.
// Optional SDF_BF_SCALE_EN: halve sum/difference (floor) instead of wrapping.
module sdf_r2_butterfly_stage #(
    parameter int DATA_W = 14,
    parameter int DELAY  = 2
) (
    input logic                    clk,
    input logic                    rst_n,
    sdf_r2_butterfly_stage_if.slave bus
);
    localparam int CW = $clog2(2 * DELAY);

    typedef logic signed [DATA_W-1:0] smp_t;
    typedef logic signed [DATA_W:0]   wide_t;

    logic [CW-1:0] cnt_q, cnt_d, p;
    logic          primed_q, primed_d;
    logic          vld_q, vld_d;
    logic          bf_q, bf_d;
    smp_t          ore_q, ore_d;
    smp_t          oim_q, oim_d;
    smp_t          dre_q [DELAY];
    smp_t          dre_d [DELAY];
    smp_t          dim_q [DELAY];
    smp_t          dim_d [DELAY];

    logic  acc, bf_ph;
    smp_t  head_re, head_im;
    wide_t ws_re, wd_re, ws_im, wd_im;
    smp_t  sum_re, dif_re, sum_im, dif_im;

    always_comb begin
        acc     = bus.in_valid;
        p       = (acc && bus.in_sof) ? '0 : cnt_q;
        // frame length is a power of two, so the MSB marks the second half
        bf_ph   = p[CW-1];
        head_re = dre_q[0];
        head_im = dim_q[0];

        ws_re = {head_re[DATA_W-1], head_re}
              + {bus.in_real[DATA_W-1], bus.in_real};
        wd_re = {head_re[DATA_W-1], head_re}
              - {bus.in_real[DATA_W-1], bus.in_real};
        ws_im = {head_im[DATA_W-1], head_im}
              + {bus.in_imag[DATA_W-1], bus.in_imag};
        wd_im = {head_im[DATA_W-1], head_im}
              - {bus.in_imag[DATA_W-1], bus.in_imag};

`ifdef SDF_BF_SCALE_EN
        sum_re = ws_re[DATA_W:1];
        dif_re = wd_re[DATA_W:1];
        sum_im = ws_im[DATA_W:1];
        dif_im = wd_im[DATA_W:1];
`else
        sum_re = ws_re[DATA_W-1:0];
        dif_re = wd_re[DATA_W-1:0];
        sum_im = ws_im[DATA_W-1:0];
        dif_im = wd_im[DATA_W-1:0];
`endif

        cnt_d    = cnt_q;
        primed_d = primed_q;
        vld_d    = 1'b0;
        bf_d     = bf_q;
        ore_d    = ore_q;
        oim_d    = oim_q;
        dre_d    = dre_q;
        dim_d    = dim_q;

        if (acc) begin
            cnt_d    = p + CW'(1);
            primed_d = primed_q | bf_ph;
            vld_d    = primed_q | bf_ph;
            bf_d     = bf_ph;
            for (int i = 0; i < DELAY - 1; i++) begin
                dre_d[i] = dre_q[i+1];
                dim_d[i] = dim_q[i+1];
            end
            if (bf_ph) begin
                ore_d           = sum_re;
                oim_d           = sum_im;
                dre_d[DELAY-1]  = dif_re;
                dim_d[DELAY-1]  = dif_im;
            end else begin
                ore_d           = head_re;
                oim_d           = head_im;
                dre_d[DELAY-1]  = bus.in_real;
                dim_d[DELAY-1]  = bus.in_imag;
            end
        end
    end

    // carry/guard bits dropped by the reduction in one build or the other
    logic unused_bits;
    assign unused_bits = ^{ws_re[0], wd_re[0], ws_im[0], wd_im[0],
                           ws_re[DATA_W], wd_re[DATA_W],
                           ws_im[DATA_W], wd_im[DATA_W]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            primed_q <= 1'b0;
            vld_q    <= 1'b0;
            bf_q     <= 1'b0;
            ore_q    <= '0;
            oim_q    <= '0;
            for (int i = 0; i < DELAY; i++) begin
                dre_q[i] <= '0;
                dim_q[i] <= '0;
            end
        end else begin
            cnt_q    <= cnt_d;
            primed_q <= primed_d;
            vld_q    <= vld_d;
            bf_q     <= bf_d;
            ore_q    <= ore_d;
            oim_q    <= oim_d;
            dre_q    <= dre_d;
            dim_q    <= dim_d;
        end
    end

    assign bus.out_valid = vld_q;
    assign bus.out_bf    = bf_q;
    assign bus.out_real  = ore_q;
    assign bus.out_imag  = oim_q;
endmodule

// File: tb/tb_sdf_r2_butterfly_stage.sv
// Directed bench for sdf_r2_butterfly_stage at DELAY 1, 2, 4 and 8.
// Expected values are hand-derived for both scaled and wrapping builds.
module tb_sdf_r2_butterfly_stage;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

`ifdef SDF_BF_SCALE_EN
    localparam int BAS_RE [6] = '{0, 0, 2, 3, -1, -1};
    localparam int OV_RE  [4] = '{8191, -1, 0, -8192};
    localparam int OV_IM  [4] = '{20, 30, -10, -10};
    localparam int RS_RE  [14] = '{0, 0, 0, 0, 3, 2, 3, 4, -2, 5, 0, 0, 0, 5};
    localparam int IMP = 0;
`else
    localparam int BAS_RE [6] = '{0, 0, 4, 6, -2, -2};
    localparam int OV_RE  [4] = '{-2, -1, 0, 1};
    localparam int OV_IM  [4] = '{40, 60, -20, -20};
    localparam int RS_RE  [14] = '{0, 0, 0, 0, 6, 2, 3, 4, -4, 10, 0, 0, 0, 10};
    localparam int IMP = 1;
`endif
    localparam int BAS_IN [6] = '{1, 2, 3, 4, 5, 6};
    localparam int BAS_V  [6] = '{0, 0, 1, 1, 1, 1};
    localparam int BAS_BF [6] = '{0, 0, 1, 1, 0, 0};
    localparam int OV_IR  [6] = '{8191, -8192, 8191, 8191, 0, 0};
    localparam int OV_II  [6] = '{10, 20, 30, 40, 0, 0};
    localparam int RS_SOF [14] = '{1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0};
    localparam int RS_IN  [14] = '{1, 2, 3, 4, 5, 10, 0, 0, 0, 0, 0, 0, 0, 0};
    localparam int RS_V   [14] = '{0, 0, 0, 0, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1};
    localparam int RS_BF  [14] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 1, 1, 1, 0};

    sdf_r2_butterfly_stage_if #(.DATA_W(14)) b1 ();
    sdf_r2_butterfly_stage_if #(.DATA_W(14)) b2 ();
    sdf_r2_butterfly_stage_if #(.DATA_W(14)) b4 ();
    sdf_r2_butterfly_stage_if #(.DATA_W(14)) b8 ();

    sdf_r2_butterfly_stage #(.DATA_W(14), .DELAY(1)) u1 (
        .clk(clk), .rst_n(rst_n), .bus(b1.slave));
    sdf_r2_butterfly_stage #(.DATA_W(14), .DELAY(2)) u2 (
        .clk(clk), .rst_n(rst_n), .bus(b2.slave));
    sdf_r2_butterfly_stage #(.DATA_W(14), .DELAY(4)) u4 (
        .clk(clk), .rst_n(rst_n), .bus(b4.slave));
    sdf_r2_butterfly_stage #(.DATA_W(14), .DELAY(8)) u8 (
        .clk(clk), .rst_n(rst_n), .bus(b8.slave));

    task automatic chk(input string tag,
                       input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic idle_all();
        b1.in_valid = 0; b1.in_sof = 0; b1.in_real = '0; b1.in_imag = '0;
        b2.in_valid = 0; b2.in_sof = 0; b2.in_real = '0; b2.in_imag = '0;
        b4.in_valid = 0; b4.in_sof = 0; b4.in_real = '0; b4.in_imag = '0;
        b8.in_valid = 0; b8.in_sof = 0; b8.in_real = '0; b8.in_imag = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle_all();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic st2(input logic v, input logic sof,
                       input int re, input int im);
        @(negedge clk);
        b2.in_valid = v;
        b2.in_sof   = sof;
        b2.in_real  = 14'(re);
        b2.in_imag  = 14'(im);
        @(posedge clk);
        #1;
    endtask

    task automatic st4(input logic v, input logic sof, input int re);
        @(negedge clk);
        b4.in_valid = v;
        b4.in_sof   = sof;
        b4.in_real  = 14'(re);
        b4.in_imag  = '0;
        @(posedge clk);
        #1;
    endtask

    task automatic swp(input string nm, input int d, input logic ov,
                       input logic bf, input logic signed [13:0] re,
                       input logic signed [13:0] im, inout int m);
        if (ov) begin
            chk($sformatf("%s_re%0d", nm, m), re, (m % d == 0) ? IMP : 0);
            chk($sformatf("%s_bf%0d", nm, m), bf, ((m / d) % 2 == 0) ? 1 : 0);
            chk($sformatf("%s_im%0d", nm, m), im, 0);
            m++;
        end
    endtask

    task automatic basic_run(input string nm);
        for (int i = 0; i < 6; i++) begin
            st2(1, 0, BAS_IN[i], 0);
            chk($sformatf("%s_v%0d", nm, i), b2.out_valid, BAS_V[i]);
            chk($sformatf("%s_bf%0d", nm, i), b2.out_bf, BAS_BF[i]);
            chk($sformatf("%s_re%0d", nm, i), b2.out_real, BAS_RE[i]);
            chk($sformatf("%s_im%0d", nm, i), b2.out_imag, 0);
        end
    endtask

    initial begin
        int m1, m2, m8;
        idle_all();
        #12;
        chk("rst_v", b2.out_valid, 0);
        chk("rst_bf", b2.out_bf, 0);
        chk("rst_re", b2.out_real, 0);
        chk("rst_im", b2.out_imag, 0);
        do_reset();

        basic_run("basic");

        do_reset();
        for (int i = 0; i < 6; i++) begin
            st2(1, 0, BAS_IN[i], 0);
            chk($sformatf("stall_v%0d", i), b2.out_valid, BAS_V[i]);
            chk($sformatf("stall_re%0d", i), b2.out_real, BAS_RE[i]);
            for (int g = 0; g < 3; g++) begin
                st2(0, 0, 99, 99);
                chk($sformatf("gap_v%0d_%0d", i, g), b2.out_valid, 0);
                chk($sformatf("gap_re%0d_%0d", i, g), b2.out_real, BAS_RE[i]);
                chk($sformatf("gap_bf%0d_%0d", i, g), b2.out_bf, BAS_BF[i]);
            end
        end

        do_reset();
        for (int i = 0; i < 6; i++) begin
            st2(1, 0, OV_IR[i], OV_II[i]);
            if (i >= 2) begin
                chk($sformatf("ovf_re%0d", i), b2.out_real, OV_RE[i-2]);
                chk($sformatf("ovf_im%0d", i), b2.out_imag, OV_IM[i-2]);
            end
        end

        do_reset();
        for (int i = 0; i < 14; i++) begin
            st4(1, RS_SOF[i][0], RS_IN[i]);
            chk($sformatf("rsync_v%0d", i), b4.out_valid, RS_V[i]);
            if (RS_V[i] != 0) begin
                chk($sformatf("rsync_bf%0d", i), b4.out_bf, RS_BF[i]);
                chk($sformatf("rsync_re%0d", i), b4.out_real, RS_RE[i]);
            end
        end

        do_reset();
        st2(1, 0, 1, 0);
        st2(1, 0, 2, 0);
        st2(1, 0, 3, 7);
        chk("mid_pre_v", b2.out_valid, 1);
        @(negedge clk);
        idle_all();
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_v", b2.out_valid, 0);
        chk("mid_rst_re", b2.out_real, 0);
        chk("mid_rst_im", b2.out_imag, 0);
        chk("mid_rst_bf", b2.out_bf, 0);
        @(negedge clk);
        rst_n = 1'b1;
        basic_run("restart");

        do_reset();
        m1 = 0;
        m2 = 0;
        m8 = 0;
        for (int k = 0; k < 32; k++) begin
            @(negedge clk);
            b1.in_valid = 1;
            b2.in_valid = 1;
            b8.in_valid = 1;
            b1.in_real  = (k % 2 == 0) ? 14'sd1 : 14'sd0;
            b2.in_real  = (k % 4 == 0) ? 14'sd1 : 14'sd0;
            b8.in_real  = (k % 16 == 0) ? 14'sd1 : 14'sd0;
            @(posedge clk);
            #1;
            swp("d1", 1, b1.out_valid, b1.out_bf, b1.out_real, b1.out_imag, m1);
            swp("d2", 2, b2.out_valid, b2.out_bf, b2.out_real, b2.out_imag, m2);
            swp("d8", 8, b8.out_valid, b8.out_bf, b8.out_real, b8.out_imag, m8);
        end
        chk("d1_count", m1, 31);
        chk("d2_count", m2, 30);
        chk("d8_count", m8, 24);

        @(negedge clk);
        idle_all();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
